// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Byte receive buffer between UART receiver and APB read side.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo #(
  parameter  int DEPTH      = 16,
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wvalid_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  input  logic                  flush_i,
  input  logic                  ovf_clear_i,
  input  logic [CNT_WIDTH-1:0]  thresh_i,
  output logic [CNT_WIDTH-1:0]  level_o,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic                  thresh_o
);

  localparam int                   PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] C_DEPTH   = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // All flags come from the registered count so nothing combinational
  // leaks from the write strobe or the consumer ready.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && rready_i && !flush_i;
  assign w_push  = wvalid_i && (!w_full || w_pop) && !flush_i;
  assign w_drop  = wvalid_i && w_full && !w_pop && !flush_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clear_i) begin
      r_overflow <= 1'b0;
    end
  end

  assign rdata_o    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign rvalid_o   = !w_empty;
  assign level_o    = r_count;
  assign full_o     = w_full;
  assign overflow_o = r_overflow;
  assign thresh_o   = (thresh_i != '0) && (r_count >= thresh_i);

endmodule
`default_nettype wire
